// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the scoreboarded register file
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int ZERO_ADDR  = 0;

    // Largest count a CNT_W-bit pending counter may hold (2**CNT_W-1).
    function automatic int pending_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/pending_scoreboard.sv
// rtl/pending_scoreboard.sv - per-register in-flight producer counters
module pending_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       iss_ready,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    output logic [(1 << ADDR_W)-1:0]   pending,
    output logic [(1 << ADDR_W)-1:0]   last_one
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(pending_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [DEPTH];
    logic             iss_is_zero;
    logic             iss_accept;

    // Issues to the hardwired zero register are accepted but never tracked.
    always_comb begin
        iss_is_zero = (ZERO_REG != 0) && (iss_addr == ADDR_W'(ZERO_ADDR));
        iss_ready   = iss_is_zero || (cnt[iss_addr] != CNT_MAX);
        iss_accept  = iss_valid && iss_ready && !iss_is_zero;
    end

    // Count up on accepted issue, down on retiring write; both together cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (iss_accept && (iss_addr == ADDR_W'(r))
                    && !(wr_en && (wr_addr == ADDR_W'(r)) && (cnt[r] != '0))) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (!(iss_accept && (iss_addr == ADDR_W'(r)))
                             && wr_en && (wr_addr == ADDR_W'(r)) && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Flatten counters into raw pending and "single producer left" bits.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            pending[r]  = (cnt[r] != '0);
            last_one[r] = (cnt[r] == CNT_ONE);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with bypass and pending-write scoreboard
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int CNT_W    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_hazard,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       iss_ready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  last_one;
    logic              wr_is_zero;

    assign wr_is_zero = (ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_ADDR));

    pending_scoreboard #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .pending   (pending),
        .last_one  (last_one)
    );

    // Writeback into the data array; the zero register is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en && !wr_is_zero) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              a_is_zero;
        logic              wr_hit;

        assign a         = rd_addr[i*ADDR_W +: ADDR_W];
        assign a_is_zero = (ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR));
        assign wr_hit    = (BYPASS != 0) && wr_en && (wr_addr == a);

        // Read mux: zero register, then forwarded writeback, then stored value.
        always_comb begin
            rd_data[i*DATA_W +: DATA_W] = regs[a];
            rd_hazard[i]                = pending[a];
            if (a_is_zero) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_hazard[i]                = 1'b0;
            end else if (wr_hit) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data;
                if (last_one[a]) begin
                    rd_hazard[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the processor's single-write, two-read register file.
- Adds N combinational read ports, a hardwired zero register, and write-to-read bypass.
- Adds a per-register pending-write scoreboard: the decode stage registers in-flight producers, and writeback retires them.
- Sits between decode (reads, issue) and writeback (write); rd_hazard drives the pipeline stall logic.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports
CNT_W, 2, pending counter width per register; max in-flight writers per register = 2**CNT_W-1
BYPASS, 1, 1 = read port returns same-cycle write data; 0 = read returns stored value
ZERO_REG, 1, 1 = register 0 reads 0, is never written, never pending

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, combinational
rd_hazard  output  NUM_RD  1 = port i value is not yet valid (pending producer)
wr_en  input  1  writeback write enable
wr_addr  input  ADDR_W  writeback address
wr_data  input  DATA_W  writeback data
iss_valid  input  1  decode registers a new producer for iss_addr
iss_addr  input  ADDR_W  destination of the issuing instruction
iss_ready  output  1  1 = issue can be accepted this cycle

Behaviour:
- Reset:
  - Synchronous, active-high: on a rising clk edge with reset=1, all DEPTH registers and all pending counters become 0.
  - wr_en and iss_valid are ignored that cycle.
  - Next cycle: rd_data=0, rd_hazard=0, iss_ready=1.
  - Reset mid-operation discards all in-flight pending state.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data. With ZERO_REG=1 and wr_addr=0, nothing happens.
- Read (per port i, combinational): addr a = rd_addr[i].
  - ZERO_REG and a=0 -> rd_data=0.
  - Else if BYPASS and wr_en and wr_addr==a -> rd_data=wr_data.
  - Else -> rd_data=reg[a].
- Scoreboard: cnt[a] holds CNT_W bits, saturating logic is not used. Per edge, with inc = issue accepted to a and dec = wr_en && wr_addr==a && cnt[a]!=0:
  - inc only -> cnt+1
  - dec only -> cnt-1
  - both -> unchanged (data is still written)
  - neither -> hold
- Untracked write: a write to a register with cnt=0 updates data and leaves cnt at 0.
- Issue accept: iss_valid && iss_ready && !(ZERO_REG && iss_addr==0).
  - iss_ready = (cnt[iss_addr] != 2**CNT_W-1), combinational, no dependence on same-cycle writeback.
  - An issue to register 0 with ZERO_REG is accepted as a no-op, and iss_ready=1.
  - iss_valid while iss_ready=0 has no effect; the upstream holds.
- Hazard: rd_hazard[i] = (cnt[a] != 0), except the following force 0:
  - ZERO_REG and a=0;
  - BYPASS and wr_en && wr_addr==a && cnt[a]==1 (last producer retiring now).
- With BYPASS=0, hazard clears the cycle after the retiring write.
- Same-cycle issue to a is not visible in rd_hazard until the next cycle.
- Multiple read ports may share an address; each is evaluated independently.
- Latency: reads, hazard and ready are 0-cycle combinational; writes and count updates are visible 1 cycle after the edge (or in the same cycle via bypass).

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W/ADDR_W/NUM_RD constants;
  - ZERO_ADDR constant;
  - function for the pending max value (2**CNT_W-1).
- One sub-module, pending_scoreboard:
  - holds the DEPTH x CNT_W counter array, inc/dec update, iss_ready and raw pending bits;
  - top level holds the data array, read muxing and bypass, and combines the bypass term into rd_hazard.

Test Plan:
1. Reset: write 0xDEADBEEF to r5, then reset=1 for one edge -> rd_addr port0=5 reads 0x00000000, rd_hazard=0, iss_ready=1.
2. Zero reg: wr_en=1, wr_addr=0, wr_data=0x12345678, and issue to r0 -> port0 addr 0 reads 0, rd_hazard[0]=0, iss_ready=1, counts unchanged.
3. Bypass and hazard:
   - issue r7; next cycle port1 addr 7 gives rd_hazard=1;
   - cycle with wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5: rd_data=0xA5A5A5A5, rd_hazard=0 (BYPASS=1);
   - with BYPASS=0, the same cycle gives rd_hazard=1 and old data, then the next cycle gives 0xA5A5A5A5 with hazard 0.
4. WAW counting (CNT_W=2):
   - issue r3 three times -> iss_ready=0 for addr 3; a fourth issue is ignored;
   - one write to r3 -> hazard stays 1 (cnt=2); two more writes -> hazard 0.
5. Simultaneous events: cnt[9]=1; same edge issue r9 and write r9=0x55 -> cnt stays 1, rd_hazard=1, data=0x55.
6. Untracked write: write r12=0x1 with cnt=0 -> data 0x1, rd_hazard=0. Also assert reset while cnt[4]=2 -> cnt 0 next cycle.
